// File: rtl/mac_kbd_fifo_if.sv
// Keyboard-side bus of the M0110 responder: PS/2 event input, Mac command
// input and the response strobe back to the VIA shift-register logic.
interface mac_kbd_fifo_if;
    logic [10:0] ps2_key;    // [10] toggle, [9] press, [8] E0, [7:0] scancode
    logic [7:0]  data_out;   // command byte from the Mac
    logic        strobe_out; // command byte valid
    logic [7:0]  data_in;    // response byte to the Mac
    logic        strobe_in;  // response valid, one ce-cycle

    // Mac / PS/2 decoder side
    modport master (
        output ps2_key,
        output data_out,
        output strobe_out,
        input  data_in,
        input  strobe_in
    );

    // Keyboard responder side
    modport slave (
        input  ps2_key,
        input  data_out,
        input  strobe_out,
        output data_in,
        output strobe_in
    );
endinterface

// File: rtl/mac_kbd_fifo.sv
// PS/2 to Macintosh M0110 keyboard responder with an event FIFO.
// Key events are translated through a keycode ROM and queued as
// {class, release, code}; keypad prefixes are expanded byte by byte when the
// head entry is sent. Answers Inquiry (0x10), Instant (0x14), Model (0x16)
// and Test (0x36), one response byte per command.
// Optional build macro MAC_KBD_TYPEMATIC_FILTER_EN: drop repeated presses of
// the last pressed key until that key is released (PS/2 auto-repeat).
module mac_kbd_fifo #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMER_W     = 20,
    parameter int unsigned SHORT_TICKS = 4095,
    parameter int unsigned LONG_TICKS  = 1048575,
    parameter logic [7:0]  MODEL_ID    = 8'h0B
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ce,
    mac_kbd_fifo_if.slave                 bus,
    output logic                          capslock,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [TIMER_W-1:0] ShortCnt = TIMER_W'(SHORT_TICKS);
    localparam logic [TIMER_W-1:0] LongCnt  = TIMER_W'(LONG_TICKS);
    localparam logic [LW-1:0]      FullLvl  = LW'(FIFO_DEPTH);

    localparam logic [7:0] CmdInquiry = 8'h10;
    localparam logic [7:0] CmdInstant = 8'h14;
    localparam logic [7:0] CmdModel   = 8'h16;
    localparam logic [7:0] CmdTest    = 8'h36;
    localparam logic [7:0] NullByte   = 8'h7B;
    localparam logic [7:0] TestByte   = 8'h7D;
    localparam logic [6:0] Unmapped   = 7'h7B;
    localparam logic [8:0] CapsKey    = 9'h058;

    typedef enum logic [2:0] {
        StIdle,
        StInqWait,
        StInq,
        StInstant,
        StModel,
        StTest
    } state_e;

    // Keycode ROM: {class[1:0], 1'b0, code[6:0]}; everything else unmapped.
    function automatic logic [9:0] key_rom(input logic [8:0] idx);
        logic [9:0] e;
        case (idx)
            9'h01C:  e = 10'h001; // a
            9'h069:  e = 10'h127; // KP1
            9'h07C:  e = 10'h305; // KP*
            9'h058:  e = 10'h073; // caps lock
            9'h16B:  e = 10'h10D; // left arrow
            default: e = {3'b000, Unmapped};
        endcase
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Event capture
    // ------------------------------------------------------------------
    logic       toggle_q;
    logic       capslock_q;
    logic       ev_seen;
    logic       key_press;
    logic [8:0] key_idx;
    logic [9:0] rom_entry;
    logic [9:0] push_entry;
    logic       filt_drop;
    logic       ev_push;
    logic       caps_toggle;

`ifdef MAC_KBD_TYPEMATIC_FILTER_EN
    logic [8:0] last_key_q;
    logic       last_valid_q;
`endif

    // Decode a PS/2 event and decide whether it is queued
    always_comb begin
        ev_seen   = ce && (bus.ps2_key[10] != toggle_q);
        key_press = bus.ps2_key[9];
        key_idx   = bus.ps2_key[8:0];
        rom_entry = key_rom(key_idx);
        // ROM bit 7 is always zero, so OR-ing inserts the release flag
        push_entry = rom_entry | {2'b00, ~key_press, 7'h00};
`ifdef MAC_KBD_TYPEMATIC_FILTER_EN
        filt_drop = key_press && last_valid_q && (last_key_q == key_idx);
`else
        filt_drop = 1'b0;
`endif
        // Caps lock is a latch on the Mac: only every other press/release pair passes
        ev_push = ev_seen && !filt_drop && (rom_entry[6:0] != Unmapped) &&
                  !((key_idx == CapsKey) && capslock_q);
        caps_toggle = ev_seen && !filt_drop && (key_idx == CapsKey) && key_press;
    end

    // Toggle edge tracker and caps-lock latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            toggle_q   <= 1'b0;
            capslock_q <= 1'b0;
        end else if (ce) begin
            toggle_q <= bus.ps2_key[10];
            if (caps_toggle) begin
                capslock_q <= ~capslock_q;
            end
        end
    end

`ifdef MAC_KBD_TYPEMATIC_FILTER_EN
    // Remember the last pressed key until its release is seen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_key_q   <= 9'h000;
            last_valid_q <= 1'b0;
        end else if (ev_seen) begin
            if (key_press && !filt_drop) begin
                last_key_q   <= key_idx;
                last_valid_q <= 1'b1;
            end else if (!key_press && last_valid_q && (last_key_q == key_idx)) begin
                last_valid_q <= 1'b0;
            end
        end
    end
`endif

    assign capslock = capslock_q;

    // ------------------------------------------------------------------
    // Event FIFO and byte sequencer
    // ------------------------------------------------------------------
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [LW-1:0] level_q;
    logic [1:0]    sub_q;
    logic          overflow_q;

    logic          fifo_empty;
    logic          fifo_full;
    logic [9:0]    head;
    logic [7:0]    head_byte;
    logic          head_last;

    logic          flush;
    logic          clr_ovf;
    logic          do_push;
    logic          drop_push;
    logic          adv;
    logic          pop_now;

    // FSM-side emission decisions
    logic          emit;
    logic          emit_take;
    logic [7:0]    emit_byte;

    // Current byte of the head entry and whether it is the entry's last
    always_comb begin
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == FullLvl);
        head       = mem_q[rd_ptr_q];
        head_byte  = {head[7], head[6:0]};
        head_last  = 1'b1;
        case (head[9:8])
            2'd3: begin
                if (sub_q == 2'd0) begin
                    head_byte = {head[7], 7'h71};
                    head_last = 1'b0;
                end else if (sub_q == 2'd1) begin
                    head_byte = 8'h79;
                    head_last = 1'b0;
                end
            end
            2'd1: begin
                if (sub_q == 2'd0) begin
                    head_byte = 8'h79;
                    head_last = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Push/pop/flush arbitration; a flush discards everything in that cycle
    always_comb begin
        flush     = ce && bus.strobe_out &&
                    ((bus.data_out == CmdModel) || (bus.data_out == CmdTest));
        clr_ovf   = ce && bus.strobe_out && (bus.data_out == CmdTest);
        do_push   = ev_push && !fifo_full && !flush;
        drop_push = ev_push && fifo_full && !flush;
        adv       = ce && emit_take && !flush;
        pop_now   = adv && head_last;
    end

    // FIFO pointers, level, sub-index and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            sub_q      <= 2'd0;
            overflow_q <= 1'b0;
        end else if (ce) begin
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                level_q  <= '0;
                sub_q    <= 2'd0;
                if (clr_ovf) begin
                    overflow_q <= 1'b0;
                end
            end else begin
                if (drop_push) begin
                    overflow_q <= 1'b1;
                end
                if (do_push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop_now) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                    sub_q    <= 2'd0;
                end else if (adv) begin
                    sub_q <= sub_q + 2'd1;
                end
                case ({do_push, pop_now})
                    2'b10:   level_q <= level_q + LW'(1);
                    2'b01:   level_q <= level_q - LW'(1);
                    default: ;
                endcase
            end
        end
    end

    // FIFO storage, no reset needed: only read when non-empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign fifo_level = level_q;
    assign overflow   = overflow_q;

    // ------------------------------------------------------------------
    // Command FSM and pace counter
    // ------------------------------------------------------------------
    state_e             state_q;
    logic [TIMER_W-1:0] cnt_q;
    logic [7:0]         data_in_q;
    logic               strobe_in_q;
    logic               at_short;
    logic               at_long;

    // Which byte, if any, the current command answers with this ce-cycle
    always_comb begin
        at_short  = (cnt_q == ShortCnt);
        at_long   = (cnt_q == LongCnt);
        emit      = 1'b0;
        emit_take = 1'b0;
        emit_byte = NullByte;
        unique case (state_q)
            StInstant: begin
                if (at_short) begin
                    emit = 1'b1;
                    if (!fifo_empty) begin
                        emit_take = 1'b1;
                        emit_byte = head_byte;
                    end
                end
            end
            StModel: begin
                if (at_short) begin
                    emit      = 1'b1;
                    emit_byte = MODEL_ID;
                end
            end
            StTest: begin
                if (at_short) begin
                    emit      = 1'b1;
                    emit_byte = TestByte;
                end
            end
            StInq: begin
                if (!fifo_empty) begin
                    emit      = 1'b1;
                    emit_take = 1'b1;
                    emit_byte = head_byte;
                end else if (at_long) begin
                    emit = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Command latch, pacing and registered response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            data_in_q   <= NullByte;
            strobe_in_q <= 1'b0;
        end else if (ce) begin
            strobe_in_q <= emit;
            if (emit) begin
                data_in_q <= emit_byte;
            end
            if (bus.strobe_out) begin
                // A new command always restarts pacing, even over a live response
                cnt_q <= '0;
                case (bus.data_out)
                    CmdInquiry: state_q <= StInqWait;
                    CmdInstant: state_q <= StInstant;
                    CmdModel:   state_q <= StModel;
                    CmdTest:    state_q <= StTest;
                    default:    state_q <= StIdle;
                endcase
            end else begin
                if (!at_long) begin
                    cnt_q <= cnt_q + TIMER_W'(1);
                end
                if (emit) begin
                    state_q <= StIdle;
                end else if ((state_q == StInqWait) && at_short) begin
                    state_q <= StInq;
                end
            end
        end
    end

    assign bus.data_in   = data_in_q;
    assign bus.strobe_in = strobe_in_q;

endmodule
